iter_mul_acc: RTL and testbench
===============================

# iter_mul_acc

Parametrised iterative multiply / multiply-accumulate unit for the CPU execute stage. It serves MULT/MULTU and MADD/MADDU/MSUB/MSUBU through a start/ready handshake. It generalises the fixed 32-bit one-bit-per-cycle multiplier in three ways: configurable operand width, configurable bits retired per cycle, and accumulate modes. All operands are captured at start, so the requester need not hold its inputs.

## Interface
Parameters:
- W, 32, operand width; must be a multiple of R.
- R, 2, multiplier bits retired per cycle; legal values 1, 2, 4.

Ports:
- clk  in  1  clock; all logic updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  request a new operation; level-sensitive.
- annul_i  in  1  abort the current operation (pipeline flush).
- signed_i  in  1  1 = signed operands, 0 = unsigned.
- mode_i  in  2  00 MUL, 01 MADD (acc + p), 10 MSUB (acc − p), 11 treated as MUL.
- opdata1_i  in  W  multiplicand.
- opdata2_i  in  W  multiplier.
- acc_i  in  2W  accumulator input, {HI, LO}.
- result_o  out  2W  final result; reset value 0.
- ready_o  out  1  result valid; reset value 0.
- busy_o  out  1  high in CALC and FIX; reset value 0.

## Operation
- States: IDLE, CALC, FIX, DONE. Reset enters IDLE and clears all outputs, the counter and the internal registers.
- IDLE:
  - If start_i=1 and annul_i=0, capture the following and go to CALC: signed_i, mode_i, acc_i, the sign bits of both operands, and the magnitudes of both operands.
  - Magnitude = two's-complement negation when signed_i=1 and MSB=1, otherwise the raw value.
  - The most negative value has magnitude 2^(W−1) as an unsigned W-bit number; no special case is needed.
  - Otherwise hold result_o=0 and ready_o=0.
- CALC runs N = W/R cycles. Each cycle:
  - partial += mag1 × (next R bits of mag2, LSB first), shifted by the current position.
  - The 2W-bit partial wraps modulo 2^(2W).
  - A counter of ceil(log2(N+1)) bits tracks steps; after step N, go to FIX.
- FIX, one cycle:
  - p = −partial if signed and sign1 XOR sign2, else partial.
  - result = p, acc+p or acc−p per the captured mode, modulo 2^(2W).
  - Register result_o, set ready_o=1, go to DONE.
- DONE:
  - Hold result_o and ready_o while start_i=1.
  - When start_i=0, go to IDLE on that edge; result_o←0, ready_o←0.
- Annul:
  - annul_i=1 in CALC or FIX: go to IDLE next edge; ready_o stays 0; partial discarded.
  - annul_i=1 in DONE: same return to IDLE with outputs cleared.
  - annul_i=1 in IDLE blocks acceptance.
- Input changes after the start edge have no effect on the result.

## Timing
- Edge 0: start sampled in IDLE, operands captured.
- Edges 1..N: CALC steps.
- Edge N+1: FIX; result_o and ready_o become valid.
- Latency = N+1 edges after the start edge: 17 for W=32/R=2, 33 for R=1, 9 for R=4.
- busy_o is high from edge 0 through edge N+1, falling as ready_o rises.
- Minimum restart: start_i low for one edge in DONE (back to IDLE), then high; accepted on the next edge.
- rst overrides everything, including mid-CALC and DONE; outputs are 0 after the reset edge.
- Simultaneous start_i and annul_i in IDLE: no start.

## Test plan
- Unsigned, W=32, R=2: 0xFFFFFFFF × 0xFFFFFFFF → result_o=0xFFFFFFFE_00000001; ready_o rises exactly 17 edges after start; busy_o falls on the same edge.
- Signed: −3 × 7 → 0xFFFFFFFF_FFFFFFEB. Signed 0x80000000 × 0x80000000 → 0x40000000_00000000. Unsigned 0x80000000 × 2 → 0x00000001_00000000.
- Accumulate:
  - MADD, acc=0x1, 2 × 3 → 0x7.
  - MSUB, acc=0, 1 × 1 → 0xFFFFFFFF_FFFFFFFF.
  - MADD wrap, acc=0xFFFFFFFF_FFFFFFFF, 1 × 1 → 0.
  - mode 11 behaves as MUL.
- Operand and abort robustness:
  - Change opdata and acc_i every cycle during CALC → result unchanged.
  - annul_i pulsed at CALC step 5 → IDLE next edge, ready_o never rises.
  - A new start one cycle later returns the correct result.
- Handshake and reset:
  - Hold start_i high in DONE for 10 cycles → result_o and ready_o stable. Drop start_i → result_o=0 and ready_o=0 on the next edge.
  - Assert rst mid-CALC → all outputs 0, state IDLE.
- Parameter sweep: R ∈ {1, 2, 4}, W ∈ {8, 32}, 10k random signed/unsigned/mode vectors checked against a reference model; latency N+1 verified for each configuration.

Source files
------------

// File: rtl/iter_mul_acc.sv
// ---------------------------------------------------------------------------
// iter_mul_acc
//
// Iterative multiply / multiply-accumulate unit for the execute stage
// (MULT/MULTU, MADD/MADDU, MSUB/MSUBU). The unit retires R multiplier bits
// per cycle, so one operation takes W/R CALC cycles plus one FIX cycle.
// All operands are captured on the accepting edge, so the requester may
// change its inputs freely afterwards.
//
// Parameters:
//   W  operand width (must be a multiple of R)
//   R  multiplier bits retired per cycle (1, 2 or 4)
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   start_i    level-sensitive operation request
//   annul_i    abort the current operation (pipeline flush)
//   signed_i   1 = signed operands, 0 = unsigned
//   mode_i     00 MUL, 01 MADD (acc + p), 10 MSUB (acc - p), 11 MUL
//   opdata1_i  multiplicand
//   opdata2_i  multiplier
//   acc_i      accumulator input {HI, LO}
//   result_o   final 2W-bit result, held while in DONE
//   ready_o    result valid
//   busy_o     high while the operation is in CALC or FIX
// ---------------------------------------------------------------------------
module iter_mul_acc #(
  parameter int W = 32,
  parameter int R = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             annul_i,
  input  logic             signed_i,
  input  logic [1:0]       mode_i,
  input  logic [W-1:0]     opdata1_i,
  input  logic [W-1:0]     opdata2_i,
  input  logic [2*W-1:0]   acc_i,
  output logic [2*W-1:0]   result_o,
  output logic             ready_o,
  output logic             busy_o
);

  localparam int N  = W / R;
  localparam int CW = $clog2(N + 1);

  localparam logic [CW-1:0]  CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  // Counter value while the final CALC step is being executed.
  localparam logic [CW-1:0]  CNT_LAST = CW'(N - 1);
  localparam logic [2*W-1:0] WIDE_ZERO = {(2*W){1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_t;

  // -------------------------------------------------------------------------
  // Helper functions
  // -------------------------------------------------------------------------

  // Absolute value of an operand when it is signed and negative. The most
  // negative value maps onto 2^(W-1), which is exactly right when the result
  // is read as an unsigned W-bit number.
  function automatic logic [W-1:0] magnitude(input logic [W-1:0] op,
                                             input logic         is_signed);
    logic [W-1:0] mag;
    if (is_signed && op[W-1]) begin
      mag = {W{1'b0}} - op;
    end else begin
      mag = op;
    end
    return mag;
  endfunction

  // Product of the (already position-shifted) multiplicand with one R-bit
  // multiplier digit, built as a sum of shifted copies.
  function automatic logic [2*W-1:0] digit_product(input logic [2*W-1:0] mcand,
                                                   input logic [R-1:0]   digit);
    logic [2*W-1:0] sum;
    sum = {(2*W){1'b0}};
    for (int i = 0; i < R; i++) begin
      if (digit[i]) begin
        sum = sum + (mcand << i);
      end else begin
        sum = sum;
      end
    end
    return sum;
  endfunction

  // Final result: restore the product sign, then apply the accumulate mode.
  // Everything wraps modulo 2^(2W).
  function automatic logic [2*W-1:0] finish_result(input logic [2*W-1:0] partial,
                                                   input logic           negate,
                                                   input logic [1:0]     mode,
                                                   input logic [2*W-1:0] acc);
    logic [2*W-1:0] p;
    logic [2*W-1:0] res;
    if (negate) begin
      p = {(2*W){1'b0}} - partial;
    end else begin
      p = partial;
    end
    case (mode)
      2'b01:   res = acc + p;
      2'b10:   res = acc - p;
      default: res = p;   // 00 and 11 are plain multiply
    endcase
    return res;
  endfunction

  // -------------------------------------------------------------------------
  // Registers and next-state signals
  // -------------------------------------------------------------------------
  state_t         state_r,   state_s;
  logic [CW-1:0]  cnt_r,     cnt_s;
  logic           signed_r,  signed_s;
  logic [1:0]     mode_r,    mode_s;
  logic [2*W-1:0] acc_r,     acc_s;
  logic           sign1_r,   sign1_s;
  logic           sign2_r,   sign2_s;
  // Multiplicand magnitude, pre-shifted to the current digit position.
  logic [2*W-1:0] mcand_r,   mcand_s;
  // Multiplier magnitude; the next digit is always in the low R bits.
  logic [W-1:0]   mplier_r,  mplier_s;
  logic [2*W-1:0] partial_r, partial_s;
  logic [2*W-1:0] result_s;
  logic           ready_s;
  logic           busy_s;

  // Next-state, datapath and output computation for the multiply FSM.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    signed_s  = signed_r;
    mode_s    = mode_r;
    acc_s     = acc_r;
    sign1_s   = sign1_r;
    sign2_s   = sign2_r;
    mcand_s   = mcand_r;
    mplier_s  = mplier_r;
    partial_s = partial_r;
    result_s  = result_o;
    ready_s   = ready_o;
    busy_s    = busy_o;

    case (state_r)
      IDLE: begin
        result_s = WIDE_ZERO;
        ready_s  = 1'b0;
        busy_s   = 1'b0;
        // A flush in the same cycle as a request wins: nothing is accepted.
        if (start_i && !annul_i) begin
          signed_s  = signed_i;
          mode_s    = mode_i;
          acc_s     = acc_i;
          sign1_s   = opdata1_i[W-1];
          sign2_s   = opdata2_i[W-1];
          mcand_s   = {{W{1'b0}}, magnitude(opdata1_i, signed_i)};
          mplier_s  = magnitude(opdata2_i, signed_i);
          partial_s = WIDE_ZERO;
          cnt_s     = CNT_ZERO;
          busy_s    = 1'b1;
          state_s   = CALC;
        end else begin
          state_s   = IDLE;
        end
      end

      CALC: begin
        if (annul_i) begin
          partial_s = WIDE_ZERO;
          cnt_s     = CNT_ZERO;
          busy_s    = 1'b0;
          ready_s   = 1'b0;
          state_s   = IDLE;
        end else begin
          partial_s = partial_r + digit_product(mcand_r, mplier_r[R-1:0]);
          mcand_s   = mcand_r << R;
          mplier_s  = mplier_r >> R;
          cnt_s     = cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            state_s = FIX;
          end else begin
            state_s = CALC;
          end
        end
      end

      FIX: begin
        if (annul_i) begin
          partial_s = WIDE_ZERO;
          cnt_s     = CNT_ZERO;
          result_s  = WIDE_ZERO;
          busy_s    = 1'b0;
          ready_s   = 1'b0;
          state_s   = IDLE;
        end else begin
          result_s  = finish_result(partial_r, signed_r & (sign1_r ^ sign2_r),
                                    mode_r, acc_r);
          ready_s   = 1'b1;
          busy_s    = 1'b0;
          state_s   = DONE;
        end
      end

      DONE: begin
        // The result is held only while the requester keeps start_i high.
        if (annul_i || !start_i) begin
          result_s = WIDE_ZERO;
          ready_s  = 1'b0;
          busy_s   = 1'b0;
          state_s  = IDLE;
        end else begin
          state_s  = DONE;
        end
      end

      default: begin
        partial_s = WIDE_ZERO;
        cnt_s     = CNT_ZERO;
        result_s  = WIDE_ZERO;
        ready_s   = 1'b0;
        busy_s    = 1'b0;
        state_s   = IDLE;
      end
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= CNT_ZERO;
      signed_r  <= 1'b0;
      mode_r    <= 2'b00;
      acc_r     <= WIDE_ZERO;
      sign1_r   <= 1'b0;
      sign2_r   <= 1'b0;
      mcand_r   <= WIDE_ZERO;
      mplier_r  <= {W{1'b0}};
      partial_r <= WIDE_ZERO;
      result_o  <= WIDE_ZERO;
      ready_o   <= 1'b0;
      busy_o    <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      signed_r  <= signed_s;
      mode_r    <= mode_s;
      acc_r     <= acc_s;
      sign1_r   <= sign1_s;
      sign2_r   <= sign2_s;
      mcand_r   <= mcand_s;
      mplier_r  <= mplier_s;
      partial_r <= partial_s;
      result_o  <= result_s;
      ready_o   <= ready_s;
      busy_o    <= busy_s;
    end
  end

endmodule

// File: tb/tb_iter_mul_acc.sv
// ---------------------------------------------------------------------------
// tb_iter_mul_acc
//
// Directed self-checking bench for iter_mul_acc. The main instance is the
// W=32/R=2 configuration; two W=8 instances (R=1 and R=4) share one set of
// inputs to cover latency and results for other retire rates.
// ---------------------------------------------------------------------------
module tb_iter_mul_acc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance, W=32 R=2
  logic        rst;
  logic        start;
  logic        annul;
  logic        sgn;
  logic [1:0]  mode;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [63:0] acc;
  logic [63:0] result;
  logic        ready;
  logic        busy;

  // Shared stimulus for the W=8 instances
  logic        s_start;
  logic        s_annul;
  logic        s_sgn;
  logic [1:0]  s_mode;
  logic [7:0]  s_op1;
  logic [7:0]  s_op2;
  logic [15:0] s_acc;
  logic [15:0] s1_result;
  logic        s1_ready;
  logic        s1_busy;
  logic [15:0] s4_result;
  logic        s4_ready;
  logic        s4_busy;

  int vectors     = 0;
  int miscompares = 0;

  iter_mul_acc #(.W(32), .R(2)) dut (
    .clk(clk), .rst(rst), .start_i(start), .annul_i(annul), .signed_i(sgn),
    .mode_i(mode), .opdata1_i(op1), .opdata2_i(op2), .acc_i(acc),
    .result_o(result), .ready_o(ready), .busy_o(busy)
  );

  iter_mul_acc #(.W(8), .R(1)) dut_w8_r1 (
    .clk(clk), .rst(rst), .start_i(s_start), .annul_i(s_annul), .signed_i(s_sgn),
    .mode_i(s_mode), .opdata1_i(s_op1), .opdata2_i(s_op2), .acc_i(s_acc),
    .result_o(s1_result), .ready_o(s1_ready), .busy_o(s1_busy)
  );

  iter_mul_acc #(.W(8), .R(4)) dut_w8_r4 (
    .clk(clk), .rst(rst), .start_i(s_start), .annul_i(s_annul), .signed_i(s_sgn),
    .mode_i(s_mode), .opdata1_i(s_op1), .opdata2_i(s_op2), .acc_i(s_acc),
    .result_o(s4_result), .ready_o(s4_ready), .busy_o(s4_busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation on the main instance. With hold=1 start stays high so the
  // unit remains in DONE when the task returns.
  task automatic run_op(input logic sg, input logic [1:0] md,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] ac, input logic [63:0] expv,
                        input logic scramble, input logic hold, input string tag);
    int  lat;
    logic got;
    sgn = sg; mode = md; op1 = a; op2 = b; acc = ac; annul = 1'b0;
    start = 1'b1;
    tick();
    check({tag, "/busy_after_start"}, {63'd0, busy}, 64'd1);
    if (!hold) start = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 60) begin
      if (scramble) begin
        op1 = $urandom; op2 = $urandom;
        acc = {$urandom, $urandom};
        sgn = $urandom_range(0, 1);
        mode = 2'($urandom_range(0, 3));
      end
      tick();
      lat++;
      if (ready) got = 1'b1;
    end
    check({tag, "/latency"}, 64'(lat), 64'd17);
    check({tag, "/result"}, result, expv);
    check({tag, "/busy_at_ready"}, {63'd0, busy}, 64'd0);
    if (!hold) tick();
  endtask

  // One operation on both W=8 instances; latencies 9 (R=1) and 3 (R=4).
  task automatic run_small(input logic sg, input logic [1:0] md,
                           input logic [7:0] a, input logic [7:0] b,
                           input logic [15:0] ac, input logic [15:0] expv,
                           input string tag);
    int lat1;
    int lat4;
    logic [15:0] r1;
    logic [15:0] r4;
    s_sgn = sg; s_mode = md; s_op1 = a; s_op2 = b; s_acc = ac;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    lat1 = 0; lat4 = 0; r1 = 16'd0; r4 = 16'd0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (s1_ready && lat1 == 0) begin lat1 = n; r1 = s1_result; end
      if (s4_ready && lat4 == 0) begin lat4 = n; r4 = s4_result; end
    end
    check({tag, "/r1_latency"}, 64'(lat1), 64'd9);
    check({tag, "/r4_latency"}, 64'(lat4), 64'd3);
    check({tag, "/r1_result"}, {48'd0, r1}, {48'd0, expv});
    check({tag, "/r4_result"}, {48'd0, r4}, {48'd0, expv});
  endtask

  logic seen_ready;

  initial begin
    rst = 1'b1; start = 1'b0; annul = 1'b0; sgn = 1'b0; mode = 2'b00;
    op1 = 32'd0; op2 = 32'd0; acc = 64'd0;
    s_start = 1'b0; s_annul = 1'b0; s_sgn = 1'b0; s_mode = 2'b00;
    s_op1 = 8'd0; s_op2 = 8'd0; s_acc = 16'd0;
    repeat (3) tick();
    check("reset/result", result, 64'd0);
    check("reset/ready", {63'd0, ready}, 64'd0);
    check("reset/busy", {63'd0, busy}, 64'd0);
    rst = 1'b0;
    tick();

    // Plain multiplies
    run_op(1'b0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 64'hFFFF_FFFE_0000_0001, 1'b0, 1'b0, "umul_max");
    run_op(1'b1, 2'b00, 32'hFFFF_FFFD, 32'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 1'b0, "smul_m3x7");
    run_op(1'b0, 2'b00, 32'hFFFF_FFFD, 32'd7, 64'd0, 64'h0000_0006_FFFF_FFEB, 1'b0, 1'b0, "umul_fffffffdx7");
    run_op(1'b1, 2'b00, 32'h8000_0000, 32'h8000_0000, 64'd0, 64'h4000_0000_0000_0000, 1'b0, 1'b0, "smul_minxmin");
    run_op(1'b0, 2'b00, 32'h8000_0000, 32'd2, 64'd0, 64'h0000_0001_0000_0000, 1'b0, 1'b0, "umul_msbx2");

    // Accumulate modes
    run_op(1'b0, 2'b01, 32'd2, 32'd3, 64'd1, 64'd7, 1'b0, 1'b0, "madd");
    run_op(1'b0, 2'b10, 32'd1, 32'd1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, "msub_wrap");
    run_op(1'b0, 2'b01, 32'd1, 32'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b0, "madd_wrap");
    run_op(1'b1, 2'b10, 32'hFFFF_FFFE, 32'd3, 64'd10, 64'd16, 1'b0, 1'b0, "smsub_neg");
    run_op(1'b0, 2'b11, 32'd5, 32'd6, 64'h123, 64'd30, 1'b0, 1'b0, "mode11");

    // Inputs scrambled every cycle after capture
    run_op(1'b1, 2'b01, 32'hFFFF_FFFD, 32'd7, 64'd100, 64'd79, 1'b1, 1'b0, "scramble");

    // Annul during CALC step 5
    sgn = 1'b0; mode = 2'b00; op1 = 32'd9; op2 = 32'd9; acc = 64'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    annul = 1'b1;
    tick();
    annul = 1'b0;
    check("annul/busy", {63'd0, busy}, 64'd0);
    check("annul/ready", {63'd0, ready}, 64'd0);
    seen_ready = 1'b0;
    repeat (20) begin
      tick();
      if (ready) seen_ready = 1'b1;
    end
    check("annul/no_ready", {63'd0, seen_ready}, 64'd0);
    run_op(1'b0, 2'b00, 32'd12, 32'd11, 64'd0, 64'd132, 1'b0, 1'b0, "after_annul");

    // Simultaneous start and annul in IDLE
    start = 1'b1; annul = 1'b1;
    repeat (3) tick();
    check("start_annul/busy", {63'd0, busy}, 64'd0);
    start = 1'b0; annul = 1'b0;
    tick();

    // Hold in DONE, then release
    run_op(1'b0, 2'b00, 32'd1000, 32'd1000, 64'd0, 64'd1000000, 1'b0, 1'b1, "hold");
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold/ready", {63'd0, ready}, 64'd1);
      check("hold/result", result, 64'd1000000);
    end
    start = 1'b0;
    tick();
    check("release/result", result, 64'd0);
    check("release/ready", {63'd0, ready}, 64'd0);

    // Reset while in DONE
    run_op(1'b0, 2'b00, 32'd3, 32'd4, 64'd0, 64'd12, 1'b0, 1'b1, "done_rst");
    rst = 1'b1;
    tick();
    check("done_rst/result", result, 64'd0);
    check("done_rst/ready", {63'd0, ready}, 64'd0);
    rst = 1'b0; start = 1'b0;
    tick();

    // Reset mid-CALC
    sgn = 1'b0; mode = 2'b00; op1 = 32'd77; op2 = 32'd77; acc = 64'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    check("calc_rst/result", result, 64'd0);
    check("calc_rst/ready", {63'd0, ready}, 64'd0);
    check("calc_rst/busy", {63'd0, busy}, 64'd0);
    rst = 1'b0;
    tick();
    run_op(1'b1, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 64'd1, 1'b0, 1'b0, "after_rst");

    // Other retire rates at W=8
    run_small(1'b0, 2'b00, 8'hFF, 8'hFF, 16'd0, 16'hFE01, "w8_umax");
    run_small(1'b1, 2'b00, 8'hFD, 8'h07, 16'd0, 16'hFFEB, "w8_sneg");
    run_small(1'b1, 2'b00, 8'h80, 8'h80, 16'd0, 16'h4000, "w8_smin");
    run_small(1'b0, 2'b01, 8'h10, 8'h10, 16'h0100, 16'h0200, "w8_madd");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
